// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential divider.
// State encoding and the default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_w.sv
// Parameterized ripple adder/subtractor.
// SEL=1 inverts B and injects a carry-in, giving A - B.
module addsub_w #(
  parameter int W = 5
) (
  output logic         OF,
  output logic         C_OUT,
  output logic [W-1:0] SUM,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         SEL
);

  logic [W-1:0] b_x;

  assign b_x = B ^ {W{SEL}};
  assign {C_OUT, SUM} = {1'b0, A} + {1'b0, b_x}
                      + {{W{1'b0}}, SEL};
  assign OF = (A[W-1] == b_x[W-1])
           && (SUM[W-1] != A[W-1]);

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Start/done handshake; divide-by-zero finishes in a single cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIVZ
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;
  logic             c_out;
  logic             addsub_of_unused;

  assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};

  // Carry-out high means no borrow: the trial subtraction fits.
  addsub_w #(.W(WIDTH + 1)) u_addsub (
    .OF    (addsub_of_unused),
    .C_OUT (c_out),
    .SUM   (diff),
    .A     (r_sh),
    .B     ({1'b0, d}),
    .SEL   (1'b1)
  );

  assign q_nx = {q[WIDTH-2:0], c_out};
  assign r_nx = c_out ? diff : r_sh;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      count <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      QUOT  <= '0;
      REM   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      DIVZ  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            BUSY <= 1'b1;
            d    <= DIVISOR;
            if (DIVISOR == '0) begin
              QUOT  <= '1;
              REM   <= DIVIDEND;
              DIVZ  <= 1'b1;
              DONE  <= 1'b1;
              state <= FINISH;
            end else begin
              DIVZ  <= 1'b0;
              q     <= DIVIDEND;
              r     <= '0;
              count <= CW'(WIDTH - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          q <= q_nx;
          r <= r_nx;
          // Results are published as FINISH is entered.
          if (count == '0) begin
            QUOT  <= q_nx;
            REM   <= r_nx[WIDTH-1:0];
            DONE  <= 1'b1;
            state <= FINISH;
          end else begin
            count <= count - CW'(1);
          end
        end
        FINISH: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
